// File: rtl/vnu_pipe_if.sv
// vnu_pipe_if: streaming bus of the variable node unit.
//   in_valid/in_ready   input beat handshake (master drives valid, slave drives ready)
//   first_iter          beat belongs to iteration 0, all CNU messages read as 0
//   x_in                DV sign-magnitude CNU messages, lane i = x_in[i*MSG_W +: MSG_W]
//   z_in                two's complement intrinsic LLR
//   out_valid/out_ready output beat handshake (slave drives valid, master drives ready)
//   y_out               DV sign-magnitude extrinsic messages, lane order matches x_in
//   hard_dec            hard decision of the beat
interface vnu_pipe_if #(
    parameter int DV    = 3,
    parameter int MSG_W = 5,
    parameter int LLR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  first_iter;
    logic [DV*MSG_W-1:0]   x_in;
    logic [LLR_W-1:0]      z_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DV*MSG_W-1:0]   y_out;
    logic                  hard_dec;

    modport master (
        output in_valid, first_iter, x_in, z_in, out_ready,
        input  in_ready, out_valid, y_out, hard_dec
    );

    modport slave (
        input  in_valid, first_iter, x_in, z_in, out_ready,
        output in_ready, out_valid, y_out, hard_dec
    );
endinterface

// File: rtl/vnu_pipe.sv
// vnu_pipe: two-stage pipelined min-sum LDPC variable node unit of column degree DV.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        vnu_pipe_if slave: input beat (x_in, z_in, first_iter) and output beat (y_out, hard_dec)
//   clr_cnt    synchronous clear of sat_count, wins over an increment
//   sat_count  number of clamped output lanes since reset/clear, saturating
module vnu_pipe #(
    parameter int DV    = 3,
    parameter int MSG_W = 5,
    parameter int LLR_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    vnu_pipe_if.slave        bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] sat_count
);
    localparam int MAX_W = MSG_W > LLR_W ? MSG_W : LLR_W;
    localparam int SUM_W = MAX_W + $clog2(DV + 1);
    localparam int NW    = $clog2(DV + 1);
    localparam int MAG_W = MSG_W - 1;
    localparam logic [SUM_W-1:0] MAX_MAG = SUM_W'((1 << MAG_W) - 1);

    logic signed [SUM_W-1:0] x_tc [DV];
    logic signed [SUM_W-1:0] t_d, t_q;
    logic signed [SUM_W-1:0] e_d [DV];
    logic signed [SUM_W-1:0] e_q [DV];
    logic        [SUM_W-1:0] abs_e [DV];
    logic [DV-1:0]           sat_lane;
    logic                    s1_v_q, s2_v_q;
    logic                    s1_load, s1_move, s2_load;
    logic [DV*MSG_W-1:0]     y_d, y_q;
    logic                    hd_d, hd_q;
    logic [NW-1:0]           nsat;
    logic [CNT_W+NW-1:0]     cnt_sum;
    logic [CNT_W-1:0]        cnt_d, cnt_q;

    // S2 frees up when empty or drained; S1 can take a beat when empty or draining into S2.
    assign s2_load      = !s2_v_q || bus.out_ready;
    assign s1_move      = s1_v_q && s2_load;
    assign bus.in_ready = !s1_v_q || s1_move;
    assign s1_load      = bus.in_valid && bus.in_ready;

    // Stage 1: sign-magnitude to two's complement (-0 becomes 0), total and leave-one-out sums.
    always_comb begin
        t_d = SUM_W'($signed(bus.z_in));
        for (int i = 0; i < DV; i++) begin
            x_tc[i] = bus.first_iter ? '0 :
                      bus.x_in[i*MSG_W+MAG_W] ? -SUM_W'(bus.x_in[i*MSG_W +: MAG_W])
                                              :  SUM_W'(bus.x_in[i*MSG_W +: MAG_W]);
            t_d = t_d + x_tc[i];
        end
        for (int i = 0; i < DV; i++)
            e_d[i] = t_d - x_tc[i];
    end

    // Stage 2: back to sign-magnitude with magnitude clamp; a zero result keeps sign 0.
    always_comb begin
        y_d      = '0;
        nsat     = '0;
        sat_lane = '0;
        for (int i = 0; i < DV; i++) begin
            abs_e[i]    = e_q[i][SUM_W-1] ? -e_q[i] : e_q[i];
            sat_lane[i] = abs_e[i] > MAX_MAG;
            y_d[i*MSG_W +: MSG_W] = {e_q[i][SUM_W-1],
                                     sat_lane[i] ? MAX_MAG[MAG_W-1:0] : abs_e[i][MAG_W-1:0]};
            nsat = nsat + NW'(sat_lane[i]);
        end
        hd_d = t_q[SUM_W-1] || t_q == '0;
    end

    // Counter sum carries NW extra bits so any overflow is visible and clamps to all-ones.
    assign cnt_sum = {{NW{1'b0}}, cnt_q} + {{CNT_W{1'b0}}, nsat};
    assign cnt_d   = clr_cnt  ? '0 :
                     !s1_move ? cnt_q :
                     |cnt_sum[CNT_W+NW-1:CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            t_q    <= '0;
            e_q    <= '{default: '0};
            y_q    <= '0;
            hd_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (bus.in_ready)
                s1_v_q <= bus.in_valid;
            if (s1_load) begin
                t_q <= t_d;
                e_q <= e_d;
            end
            if (s2_load)
                s2_v_q <= s1_v_q;
            // Output data only changes on a real transfer, so it holds while stalled.
            if (s1_move) begin
                y_q  <= y_d;
                hd_q <= hd_d;
            end
        end
    end

    assign bus.out_valid = s2_v_q;
    assign bus.y_out     = y_q;
    assign bus.hard_dec  = hd_q;
    assign sat_count     = cnt_q;
endmodule

// File: tb/tb_vnu_pipe.sv
// tb_vnu_pipe: directed and random stimulus against a transaction-level reference model.
module tb_vnu_pipe;
    localparam int DV    = 3;
    localparam int MSG_W = 5;
    localparam int LLR_W = 5;
    localparam int CNT_W = 16;
    localparam int W     = DV * MSG_W;
    localparam int MAG_W = MSG_W - 1;
    localparam int MAXM  = (1 << MAG_W) - 1;

    typedef struct {
        logic [W-1:0] y;
        logic         hd;
        int           nsat;
        bit           in_s2;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] sat_count;
    logic [1:0]       sat_count2;

    beat_t q[$];
    int    cnt16, cnt2;
    int    checks, errors;

    always #5 clk = ~clk;

    vnu_pipe_if #(.DV(DV), .MSG_W(MSG_W), .LLR_W(LLR_W)) bus ();
    vnu_pipe_if #(.DV(DV), .MSG_W(MSG_W), .LLR_W(LLR_W)) bus2 ();

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.first_iter = bus.first_iter;
    assign bus2.x_in       = bus.x_in;
    assign bus2.z_in       = bus.z_in;
    assign bus2.out_ready  = bus.out_ready;

    vnu_pipe #(.DV(DV), .MSG_W(MSG_W), .LLR_W(LLR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_cnt(clr_cnt), .sat_count(sat_count)
    );

    vnu_pipe #(.DV(DV), .MSG_W(MSG_W), .LLR_W(LLR_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .clr_cnt(clr_cnt), .sat_count(sat_count2)
    );

    function automatic beat_t model(logic [W-1:0] x, logic [LLR_W-1:0] z, logic first);
        int    xv[DV];
        int    t, e, m;
        beat_t b;
        t = int'($signed(z));
        for (int i = 0; i < DV; i++) begin
            xv[i] = first ? 0 : x[i*MSG_W+MAG_W] ? -int'(x[i*MSG_W +: MAG_W]) : int'(x[i*MSG_W +: MAG_W]);
            t += xv[i];
        end
        b.y    = '0;
        b.nsat = 0;
        for (int i = 0; i < DV; i++) begin
            e = t - xv[i];
            m = e < 0 ? -e : e;
            if (m > MAXM) begin
                m = MAXM;
                b.nsat++;
            end
            b.y[i*MSG_W +: MSG_W] = {e < 0, MAG_W'(m)};
        end
        b.hd    = t <= 0;
        b.in_s2 = 1'b0;
        return b;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model across the edge.
    task automatic cyc(bit iv, bit first, logic [W-1:0] x, logic [LLR_W-1:0] z, bit ordy, bit clr,
                       output bit in_fire);
        bit    exp_ov, exp_ir, out_fire;
        beat_t nb, f;
        bus.in_valid   = iv;
        bus.first_iter = first;
        bus.x_in       = x;
        bus.z_in       = z;
        bus.out_ready  = ordy;
        clr_cnt        = clr;
        #1;
        exp_ov = q.size() > 0 && q[0].in_s2;
        exp_ir = !(q.size() == 2 && !ordy);
        check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        check("in_ready", 64'(bus.in_ready), 64'(exp_ir));
        if (exp_ov) begin
            check("y_out", 64'(bus.y_out), 64'(q[0].y));
            check("hard_dec", 64'(bus.hard_dec), 64'(q[0].hd));
        end
        check("sat_count", 64'(sat_count), 64'(cnt16));
        check("sat_count_w2", 64'(sat_count2), 64'(cnt2));
        in_fire  = iv && exp_ir;
        out_fire = exp_ov && ordy;
        if (in_fire)
            nb = model(x, z, first);
        @(posedge clk);
        if (out_fire)
            void'(q.pop_front());
        if (q.size() > 0 && !q[0].in_s2) begin
            f       = q[0];
            f.in_s2 = 1'b1;
            q[0]    = f;
            cnt16   = cnt16 + f.nsat > 65535 ? 65535 : cnt16 + f.nsat;
            cnt2    = cnt2 + f.nsat > 3 ? 3 : cnt2 + f.nsat;
        end
        if (clr) begin
            cnt16 = 0;
            cnt2  = 0;
        end
        if (in_fire)
            q.push_back(nb);
        #1;
    endtask

    task automatic idle(bit clr);
        bit fired;
        cyc(1'b0, 1'b0, W'($urandom), LLR_W'($urandom), 1'b1, clr, fired);
    endtask

    task automatic beat(logic [W-1:0] x, logic [LLR_W-1:0] z, bit first, bit clr);
        bit fired;
        cyc(1'b1, first, x, z, 1'b1, clr, fired);
    endtask

    initial begin
        bit fired;
        int sent, c;
        bus.in_valid   = 1'b0;
        bus.first_iter = 1'b0;
        bus.x_in       = '0;
        bus.z_in       = '0;
        bus.out_ready  = 1'b0;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_y_out", 64'(bus.y_out), 64'(0));
        check("rst_hard_dec", 64'(bus.hard_dec), 64'(0));
        check("rst_sat_count", 64'(sat_count), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic beat: X=(+3,-2,+5), Z=+4
        beat({5'b00101, 5'b10010, 5'b00011}, 5'd4, 1'b0, 1'b0);
        idle(1'b0);
        check("ex1_y", 64'(bus.y_out), 64'(15'b00101_01100_00111));
        check("ex1_hd", 64'(bus.hard_dec), 64'(0));
        idle(1'b0);
        idle(1'b1);

        // Clamp both signs: +45 then -46
        beat({5'b01111, 5'b01111, 5'b01111}, 5'b01111, 1'b0, 1'b0);
        beat({5'b11111, 5'b11111, 5'b11111}, 5'b10000, 1'b0, 1'b0);
        idle(1'b0);
        check("ex2_y", 64'(bus.y_out), 64'(15'h7fff));
        check("ex2_hd", 64'(bus.hard_dec), 64'(1));
        check("ex2_cnt", 64'(sat_count), 64'(6));
        idle(1'b0);

        // T=0 gives hard_dec=1, -0 input equals 0; then first-iteration bypass
        beat({5'b10000, 5'b10001, 5'b00001}, 5'd0, 1'b0, 1'b0);
        beat({5'b01111, 5'b10111, 5'b00110}, 5'b11101, 1'b1, 1'b0);
        check("ex3_y", 64'(bus.y_out), 64'(15'b00000_00001_10001));
        check("ex3_hd", 64'(bus.hard_dec), 64'(1));
        idle(1'b0);
        check("ex4_y", 64'(bus.y_out), 64'(15'b10011_10011_10011));
        check("ex4_hd", 64'(bus.hard_dec), 64'(1));
        idle(1'b0);

        // Stream of 6 beats with downstream stalled in cycles 2-4
        sent = 0;
        for (c = 0; c < 30 && (sent < 6 || q.size() > 0); c++) begin
            cyc(sent < 6, 1'b0, W'($urandom), LLR_W'($urandom), !(c >= 2 && c <= 4), 1'b0, fired);
            if (fired)
                sent++;
        end
        check("stream_sent", 64'(sent), 64'(6));
        check("stream_drained", 64'(q.size()), 64'(0));

        // Narrow counter saturates at 3; clear beats a same-cycle increment
        idle(1'b1);
        for (int i = 0; i < 4; i++)
            beat({5'b00000, 5'b11111, 5'b01111}, 5'b01111, 1'b0, 1'b0);
        idle(1'b0);
        check("cnt2_sat", 64'(sat_count2), 64'(3));
        check("cnt16_lin", 64'(sat_count), 64'(4));
        idle(1'b0);
        beat({5'b01111, 5'b01111, 5'b01111}, 5'b01111, 1'b0, 1'b0);
        idle(1'b1);
        check("clr_wins", 64'(sat_count), 64'(0));
        check("clr_wins_w2", 64'(sat_count2), 64'(0));
        idle(1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, W'($urandom), LLR_W'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, fired);

        // Asynchronous reset with two beats in flight
        cyc(1'b1, 1'b0, W'($urandom), LLR_W'($urandom), 1'b0, 1'b0, fired);
        cyc(1'b1, 1'b0, W'($urandom), LLR_W'($urandom), 1'b0, 1'b0, fired);
        cyc(1'b1, 1'b0, {5'b01111, 5'b01111, 5'b01111}, 5'b01111, 1'b0, 1'b0, fired);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'(0));
        check("arst_sat_count", 64'(sat_count), 64'(0));
        check("arst_y_out", 64'(bus.y_out), 64'(0));
        q.delete();
        cnt16 = 0;
        cnt2  = 0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat({5'b00011, 5'b10100, 5'b01000}, 5'b11010, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
